// File: rtl/counter_updown_mod_n.sv
// Up/down modulo-N counter with runtime modulus, parallel load, a terminal-count pulse
// and a saturating wrap tally. All outputs are registered.
module counter_updown_mod_n #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic [WIDTH-1:0]  modulus,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              load_err,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [WIDTH:0]  FULL_M   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]  ONE_M    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] ONE_W  = {{(WRAP_W-1){1'b0}}, 1'b1};

  // Top count value M = N-1, held one bit wider so modulus==0 (N = 2^WIDTH) fits.
  logic [WIDTH:0]     m_val;
  logic [WIDTH-1:0]   m_low;
  logic [WIDTH:0]     cnt_ext;
  logic [WIDTH:0]     lv_ext;
  logic [WRAP_W-1:0]  wraps_inc;

  logic [WIDTH-1:0]   count_nxt;
  logic               tc_nxt;
  logic               load_err_nxt;
  logic [WRAP_W-1:0]  wraps_nxt;

  always_comb begin
    m_val     = (modulus == '0) ? FULL_M : ({1'b0, modulus} - ONE_M);
    m_low     = m_val[WIDTH-1:0];
    cnt_ext   = {1'b0, count};
    lv_ext    = {1'b0, load_value};
    wraps_inc = (wraps == '1) ? wraps : (wraps + ONE_W);
  end

  always_comb begin
    count_nxt    = count;
    tc_nxt       = 1'b0;
    load_err_nxt = 1'b0;
    wraps_nxt    = wraps;
    if (load) begin
      if (lv_ext > m_val) begin
        count_nxt    = m_low;
        load_err_nxt = 1'b1;
      end else begin
        count_nxt    = load_value;
      end
    end else if (en) begin
      if (up) begin
        // >= also catches a count left above M after the modulus shrank.
        if (cnt_ext >= m_val) begin
          count_nxt = '0;
          tc_nxt    = 1'b1;
          wraps_nxt = wraps_inc;
        end else begin
          count_nxt = count + ONE_C;
        end
      end else begin
        if (count == '0) begin
          count_nxt = m_low;
          tc_nxt    = 1'b1;
          wraps_nxt = wraps_inc;
        end else if (cnt_ext > m_val) begin
          count_nxt = m_low;
        end else begin
          count_nxt = count - ONE_C;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
      wraps    <= '0;
    end else begin
      count    <= count_nxt;
      tc       <= tc_nxt;
      load_err <= load_err_nxt;
      wraps    <= wraps_nxt;
    end
  end

endmodule
